// File: rtl/channel_rr_arbiter_if.sv
// Blocking-channel bundle between N producers and one shared consumer.
// Producer i transfers on a posedge where in_valid[i] && !in_is_full[i]; the consumer pops on out_valid && out_is_taken.
interface channel_rr_arbiter_if #(
   parameter int N     = 4,
   parameter int WIDTH = 8,
   parameter int SRC_W = $clog2(N)
);
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_valid;
   logic [N-1:0]       in_is_full;
   logic [WIDTH-1:0]   out_data;
   logic [SRC_W-1:0]   out_source;
   logic               out_valid;
   logic               out_is_taken;

   modport master (
      output in_data, in_valid, out_is_taken,
      input  in_is_full, out_data, out_source, out_valid
   );

   modport slave (
      input  in_data, in_valid, out_is_taken,
      output in_is_full, out_data, out_source, out_valid
   );
endinterface

// File: rtl/channel_rr_arbiter.sv
// Round-robin merge of N blocking channels into one, with a registered grant
// and a 2-entry output buffer so in_is_full depends only on flops.
module channel_rr_arbiter #(
   parameter int N     = 4,
   parameter int WIDTH = 8,
   parameter int SRC_W = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 initialize,
   channel_rr_arbiter_if.slave  ch
);
   localparam int EW = SRC_W + WIDTH;

   logic             clear;
   logic             push;
   logic             pop;
   logic [1:0]       occ_q, occ_d;
   logic             gnt_valid_q, gnt_valid_d;
   logic [SRC_W-1:0] gnt_idx_q, gnt_idx_d;
   logic [SRC_W-1:0] ptr_q, ptr_d;
   logic [EW-1:0]    e0_q, e0_d;
   logic [EW-1:0]    e1_q, e1_d;
   logic [EW-1:0]    new_e;

   assign clear = !reset_n || initialize;
   assign push  = gnt_valid_q && ch.in_valid[gnt_idx_q];
   assign pop   = (occ_q != 2'd0) && ch.out_is_taken;
   assign new_e = {gnt_idx_q, ch.in_data[int'(gnt_idx_q)*WIDTH +: WIDTH]};

   assign ch.out_valid  = (occ_q != 2'd0);
   assign ch.out_source = e0_q[EW-1 -: SRC_W];
   assign ch.out_data   = e0_q[WIDTH-1:0];

   always_comb begin
      for (int i = 0; i < N; i++) begin
         ch.in_is_full[i] = !(gnt_valid_q && (gnt_idx_q == SRC_W'(i)));
      end
   end

   always_comb begin
      occ_d = occ_q + {1'b0, push} - {1'b0, pop};
      if (push) begin
         ptr_d = (gnt_idx_q == SRC_W'(N-1)) ? '0 : gnt_idx_q + SRC_W'(1);
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Circular scan from ptr_d; a requester that just transferred sits last.
   always_comb begin
      gnt_idx_d   = ptr_d;
      gnt_valid_d = 1'b0;
      for (int k = 0; k < N; k++) begin
         int j;
         j = int'(ptr_d) + k;
         if (j >= N) j = j - N;
         if (!gnt_valid_d && ch.in_valid[j]) begin
            gnt_valid_d = 1'b1;
            gnt_idx_d   = SRC_W'(j);
         end
      end
      if (occ_d > 2'd1) gnt_valid_d = 1'b0;
   end

   always_comb begin
      e0_d = e0_q;
      e1_d = e1_q;
      case ({push, pop})
         2'b10: begin
            if (occ_q == 2'd0) e0_d = new_e;
            else               e1_d = new_e;
         end
         2'b01: e0_d = e1_q;
         2'b11: begin
            if (occ_q == 2'd1) begin
               e0_d = new_e;
            end else begin
               e0_d = e1_q;
               e1_d = new_e;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         occ_q       <= 2'd0;
         gnt_valid_q <= 1'b0;
         gnt_idx_q   <= '0;
         ptr_q       <= '0;
         e0_q        <= '0;
         e1_q        <= '0;
      end else begin
         occ_q       <= occ_d;
         gnt_valid_q <= gnt_valid_d;
         gnt_idx_q   <= gnt_idx_d;
         ptr_q       <= ptr_d;
         e0_q        <= e0_d;
         e1_q        <= e1_d;
      end
   end

   // The grant rule never lets a transfer land on a full buffer.
   always_ff @(posedge clk) begin
      if (!clear) assert (!(push && occ_q == 2'd2));
   end
endmodule

// File: tb/tb_channel_rr_arbiter.sv
// Directed bench for channel_rr_arbiter with a scoreboard of accepted messages.
module tb_channel_rr_arbiter;
   localparam int N     = 4;
   localparam int WIDTH = 8;
   localparam int SRC_W = 2;
   localparam int EW    = SRC_W + WIDTH;

   logic clk;
   logic reset_n;
   logic initialize;

   channel_rr_arbiter_if #(.N(N), .WIDTH(WIDTH), .SRC_W(SRC_W)) chan ();

   channel_rr_arbiter #(.N(N), .WIDTH(WIDTH), .SRC_W(SRC_W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .initialize (initialize),
      .ch         (chan.slave)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   int          n_acc    = 0;
   int          n_pop    = 0;
   bit          rand_mode = 1'b0;
   logic [5:0]  seq [N];
   logic [EW-1:0] exp_q [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: score the transfers happening at this edge, then advance producers.
   task automatic step();
      logic [N-1:0]  acc;
      logic          pop;
      logic          clr;
      logic [EW-1:0] e;
      acc = chan.in_valid & ~chan.in_is_full;
      pop = chan.out_valid && chan.out_is_taken;
      clr = !reset_n || initialize;
      check("one_grant", 32'($countones(~chan.in_is_full) <= 1), 32'd1);
      if (clr) begin
         exp_q.delete();
      end else begin
         if (pop) begin
            n_pop++;
            if (exp_q.size() == 0) begin
               check("sb_underflow", {22'd0, chan.out_source, chan.out_data}, 32'hDEAD);
            end else begin
               e = exp_q.pop_front();
               check("sb_msg", {22'd0, chan.out_source, chan.out_data}, {22'd0, e});
            end
         end
         for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
               exp_q.push_back({SRC_W'(i), chan.in_data[i*WIDTH +: WIDTH]});
               n_acc++;
            end
         end
      end
      @(posedge clk);
      #1;
      if (!clr) begin
         for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
               seq[i] = seq[i] + 6'd1;
               chan.in_data[i*WIDTH +: WIDTH] = {SRC_W'(i), seq[i]};
               if (rand_mode) chan.in_valid[i] = 1'($urandom_range(0, 1));
            end
         end
      end
   endtask

   initial begin
      logic [3:0] exp_full;
      int         a0;
      reset_n           = 1'b0;
      initialize        = 1'b0;
      chan.in_valid     = 4'b1111;
      chan.out_is_taken = 1'b0;
      for (int i = 0; i < N; i++) begin
         seq[i] = 6'd0;
         chan.in_data[i*WIDTH +: WIDTH] = {SRC_W'(i), 6'd0};
      end

      // reset held with all requesters valid
      repeat (3) step();
      check("rst_full", 32'(chan.in_is_full), 32'hF);
      check("rst_valid", 32'(chan.out_valid), 32'd0);
      check("rst_data", 32'(chan.out_data), 32'd0);
      check("rst_src", 32'(chan.out_source), 32'd0);
      reset_n = 1'b1;
      step();
      check("rel_full", 32'(chan.in_is_full), 32'hE);
      check("rel_valid", 32'(chan.out_valid), 32'd0);
      chan.in_valid = 4'b0000;
      step();
      step();
      check("idle_full", 32'(chan.in_is_full), 32'hF);
      check("idle_valid", 32'(chan.out_valid), 32'd0);

      // single requester, minimum latency
      chan.in_data[2*WIDTH +: WIDTH] = 8'hA5;
      chan.in_valid = 4'b0100;
      step();
      check("single_full", 32'(chan.in_is_full), 32'hB);
      check("single_early", 32'(chan.out_valid), 32'd0);
      step();
      chan.in_valid = 4'b0000;
      check("single_valid", 32'(chan.out_valid), 32'd1);
      check("single_data", 32'(chan.out_data), 32'hA5);
      check("single_src", 32'(chan.out_source), 32'd2);
      chan.out_is_taken = 1'b1;
      step();
      check("single_popped", 32'(chan.out_valid), 32'd0);
      step();
      check("wasted_full", 32'(chan.in_is_full), 32'hF);

      // fairness at full rate
      initialize    = 1'b1;
      chan.in_valid = 4'b1111;
      step();
      initialize = 1'b0;
      check("fair_init_full", 32'(chan.in_is_full), 32'hF);
      step();
      check("fair_first_gnt", 32'(chan.in_is_full), 32'hE);
      for (int k = 1; k <= 12; k++) begin
         step();
         exp_full = ~(4'b0001 << (k % 4));
         check("fair_valid", 32'(chan.out_valid), 32'd1);
         check("fair_src", 32'(chan.out_source), 32'(k - 1) % 4);
         check("fair_full", 32'(chan.in_is_full), 32'(exp_full));
      end

      // backpressure from empty
      initialize        = 1'b1;
      chan.out_is_taken = 1'b0;
      step();
      initialize = 1'b0;
      a0 = n_acc;
      repeat (10) step();
      check("bp_accepted", 32'(n_acc - a0), 32'd2);
      check("bp_full", 32'(chan.in_is_full), 32'hF);
      check("bp_valid", 32'(chan.out_valid), 32'd1);
      check("bp_head_src", 32'(chan.out_source), 32'd0);
      chan.out_is_taken = 1'b1;
      repeat (12) step();
      chan.in_valid = 4'b0000;
      repeat (4) step();
      check("bp_drain", 32'(exp_q.size()), 32'd0);
      check("bp_empty", 32'(chan.out_valid), 32'd0);

      // initialize while the buffer holds two entries
      chan.in_valid     = 4'b1111;
      chan.out_is_taken = 1'b0;
      repeat (4) step();
      check("init_pre_full", 32'(chan.in_is_full), 32'hF);
      check("init_pre_valid", 32'(chan.out_valid), 32'd1);
      initialize = 1'b1;
      step();
      initialize = 1'b0;
      check("init_valid", 32'(chan.out_valid), 32'd0);
      check("init_full", 32'(chan.in_is_full), 32'hF);
      check("init_data", 32'(chan.out_data), 32'd0);
      step();
      check("init_first_gnt", 32'(chan.in_is_full), 32'hE);

      // random traffic with occasional initialize
      rand_mode = 1'b1;
      a0 = n_pop;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!chan.in_valid[i]) chan.in_valid[i] = ($urandom_range(0, 2) == 0);
         end
         chan.out_is_taken = ($urandom_range(0, 3) != 0);
         initialize        = ($urandom_range(0, 39) == 0);
         step();
      end
      rand_mode         = 1'b0;
      initialize        = 1'b0;
      chan.in_valid     = 4'b0000;
      chan.out_is_taken = 1'b1;
      repeat (4) step();
      check("rand_traffic", 32'(n_pop - a0 > 50), 32'd1);
      check("rand_drain", 32'(exp_q.size()), 32'd0);
      check("rand_empty", 32'(chan.out_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
